// File: rtl/ppi_pkg.sv
// Shared constants for the 8255-style PPI bus controller: address codes,
// FSM encodings, control-word field positions and the port read mux.
package ppi_pkg;

  typedef logic [1:0] ppi_state_t;

  localparam logic [1:0] ADDR_PA   = 2'b00;
  localparam logic [1:0] ADDR_PB   = 2'b01;
  localparam logic [1:0] ADDR_PC   = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  localparam ppi_state_t ST_IDLE   = 2'd0;
  localparam ppi_state_t ST_READ   = 2'd1;
  localparam ppi_state_t ST_WRITE  = 2'd2;
  localparam ppi_state_t ST_COMMIT = 2'd3;

  // Mode 0, ports A/B/C all inputs
  localparam logic [7:0] CTRL_RESET_DEFAULT = 8'h9B;

  localparam int MODE_SET_BIT = 7;
  localparam int BSR_BIT_MSB  = 3;
  localparam int BSR_BIT_LSB  = 1;
  localparam int BSR_VAL_BIT  = 0;

  // The control register is write-only, so its address reads back as zero.
  function automatic logic [7:0] read_mux(input logic [1:0] addr,
                                          input logic [7:0] pa,
                                          input logic [7:0] pb,
                                          input logic [7:0] pc);
    logic [7:0] r;
    r = 8'h00;
    case (addr)
      ADDR_PA: r = pa;
      ADDR_PB: r = pb;
      ADDR_PC: r = pc;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ppi_sync.sv
// Single-bit synchronizer: STAGES flops in series, async active-low reset
// to RESET_VAL (1 for the idle-high CPU strobes).
module ppi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_reg <= {STAGES{RESET_VAL}};
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/ppi_bus_controller.sv
// Read/write sequencer for the 8255-style PPI. SYNC_STAGES must be 2..3.
// Define PPI_BSR_EN to enable port C bit set/reset commands on control writes.
module ppi_bus_controller
  import ppi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CTRL_RESET  = CTRL_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] a,
  input  logic [7:0] din,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic       bus_drive,
  output logic [7:0] dout,
  output logic [7:0] wr_data,
  output logic       pa_wr,
  output logic       pb_wr,
  output logic       pc_wr,
  output logic [7:0] ctrl_word,
  output logic       bsr_valid,
  output logic [2:0] bsr_bit,
  output logic       bsr_val
);

  logic       s_cs, s_rd, s_wr;
  logic [1:0] s_a;

  ppi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .d(cs_n), .q(s_cs));
  ppi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rd (
    .clk(clk), .reset_n(reset_n), .d(rd_n), .q(s_rd));
  ppi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_wr (
    .clk(clk), .reset_n(reset_n), .d(wr_n), .q(s_wr));

  // Address resets to 00 so the synced copy matches the idle bus.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync_a
      ppi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_a (
        .clk(clk), .reset_n(reset_n), .d(a[gi]), .q(s_a[gi]));
    end
  endgenerate

  ppi_state_t state_reg, state_next;
  logic [1:0] addr_reg;
  logic [7:0] dout_reg, wr_data_reg, ctrl_word_reg;
  logic       bus_drive_reg, pa_wr_reg, pb_wr_reg, pc_wr_reg;
  logic       commit_ctrl;

  // Simultaneous rd/wr never leaves IDLE, so the buffer is never turned on.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!s_cs && !s_rd && s_wr)      state_next = ST_READ;
        else if (!s_cs && !s_wr && s_rd) state_next = ST_WRITE;
      end
      ST_READ:   if (s_rd || s_cs) state_next = ST_IDLE;
      ST_WRITE: begin
        if (s_cs)      state_next = ST_IDLE;
        else if (s_wr) state_next = ST_COMMIT;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  assign commit_ctrl = (state_reg == ST_COMMIT) && (addr_reg == ADDR_CTRL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= ADDR_PA;
      dout_reg      <= 8'h00;
      wr_data_reg   <= 8'h00;
      ctrl_word_reg <= CTRL_RESET;
      bus_drive_reg <= 1'b0;
      pa_wr_reg     <= 1'b0;
      pb_wr_reg     <= 1'b0;
      pc_wr_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus_drive_reg <= (state_next == ST_READ);
      if (state_reg == ST_IDLE && state_next == ST_WRITE) addr_reg <= s_a;
      if (state_reg == ST_READ) dout_reg <= read_mux(s_a, pa_in, pb_in, pc_in);
      if (state_reg == ST_WRITE) wr_data_reg <= din;
      pa_wr_reg <= (state_reg == ST_COMMIT) && (addr_reg == ADDR_PA);
      pb_wr_reg <= (state_reg == ST_COMMIT) && (addr_reg == ADDR_PB);
      pc_wr_reg <= (state_reg == ST_COMMIT) && (addr_reg == ADDR_PC);
      if (commit_ctrl && wr_data_reg[MODE_SET_BIT]) ctrl_word_reg <= wr_data_reg;
    end
  end

`ifdef PPI_BSR_EN
  logic       bsr_valid_reg, bsr_val_reg;
  logic [2:0] bsr_bit_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bsr_valid_reg <= 1'b0;
      bsr_bit_reg   <= 3'd0;
      bsr_val_reg   <= 1'b0;
    end else begin
      bsr_valid_reg <= commit_ctrl && !wr_data_reg[MODE_SET_BIT];
      if (commit_ctrl && !wr_data_reg[MODE_SET_BIT]) begin
        bsr_bit_reg <= wr_data_reg[BSR_BIT_MSB:BSR_BIT_LSB];
        bsr_val_reg <= wr_data_reg[BSR_VAL_BIT];
      end
    end
  end

  assign bsr_valid = bsr_valid_reg;
  assign bsr_bit   = bsr_bit_reg;
  assign bsr_val   = bsr_val_reg;
`else
  assign bsr_valid = 1'b0;
  assign bsr_bit   = 3'd0;
  assign bsr_val   = 1'b0;
`endif

  assign bus_drive = bus_drive_reg;
  assign dout      = dout_reg;
  assign wr_data   = wr_data_reg;
  assign pa_wr     = pa_wr_reg;
  assign pb_wr     = pb_wr_reg;
  assign pc_wr     = pc_wr_reg;
  assign ctrl_word = ctrl_word_reg;

endmodule
